// File: rtl/stop_sequencer.sv
// STOP instruction sequencer: drives the `stop` level for CGB speed switching
// and low-power STOP with joypad wake-up.
module stop_sequencer #(
  parameter int unsigned SWITCH_CYCLES = 2050,
  parameter int unsigned WAKE_CYCLES   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_en,
  input  logic stop_exec,
  input  logic prepare_switch,
  input  logic cgb,
  input  logic joypad_any,
  output logic stop,
  output logic cpu_halt,
  output logic stopped,
  output logic div_reset,
  output logic busy
);

  localparam int unsigned MAX_CYCLES = (SWITCH_CYCLES > WAKE_CYCLES) ? SWITCH_CYCLES : WAKE_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SWITCH_LOAD = CNT_W'(SWITCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD   = CNT_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    STOPPED,
    WAKE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;

  // Outputs are assigned alongside each state transition so they stay registered
  // and always match the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      counter   <= '0;
      stop      <= 1'b0;
      cpu_halt  <= 1'b0;
      stopped   <= 1'b0;
      div_reset <= 1'b0;
      busy      <= 1'b0;
    end else begin
      div_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_en && stop_exec) begin
            if (cgb && prepare_switch) begin
              state     <= SWITCH;
              counter   <= SWITCH_LOAD;
              stop      <= 1'b1;
              cpu_halt  <= 1'b1;
              busy      <= 1'b1;
              div_reset <= 1'b1;
            end else if (!joypad_any) begin
              state     <= STOPPED;
              stop      <= 1'b1;
              stopped   <= 1'b1;
              cpu_halt  <= 1'b1;
              busy      <= 1'b1;
              div_reset <= 1'b1;
            end
          end
        end
        SWITCH: begin
          if (cpu_en) begin
            if (counter == '0) begin
              state    <= IDLE;
              stop     <= 1'b0;
              cpu_halt <= 1'b0;
              busy     <= 1'b0;
            end else begin
              counter <= counter - 1'b1;
            end
          end
        end
        STOPPED: begin
          if (joypad_any) begin
            state   <= WAKE;
            counter <= WAKE_LOAD;
            stop    <= 1'b0;
            stopped <= 1'b0;
          end
        end
        WAKE: begin
          if (cpu_en) begin
            if (counter == '0) begin
              state    <= IDLE;
              cpu_halt <= 1'b0;
              busy     <= 1'b0;
            end else begin
              counter <= counter - 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          stop     <= 1'b0;
          cpu_halt <= 1'b0;
          stopped  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stop_sequencer.sv
// Directed self-checking bench for stop_sequencer (SWITCH_CYCLES=4, WAKE_CYCLES=2).
module tb_stop_sequencer;

  logic clk = 1'b0;
  logic reset_n, cpu_en, stop_exec, prepare_switch, cgb, joypad_any;
  logic stop, cpu_halt, stopped, div_reset, busy;

  int tests = 0;
  int failed = 0;

  // Expected-vector bit order: {stop, cpu_halt, stopped, div_reset, busy}
  localparam logic [4:0] O_IDLE    = 5'b00000;
  localparam logic [4:0] O_SW_ENT  = 5'b11011;
  localparam logic [4:0] O_SW      = 5'b11001;
  localparam logic [4:0] O_STP_ENT = 5'b11111;
  localparam logic [4:0] O_STP     = 5'b11101;
  localparam logic [4:0] O_WAKE    = 5'b01001;

  stop_sequencer #(.SWITCH_CYCLES(4), .WAKE_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .stop_exec(stop_exec),
    .prepare_switch(prepare_switch), .cgb(cgb), .joypad_any(joypad_any),
    .stop(stop), .cpu_halt(cpu_halt), .stopped(stopped),
    .div_reset(div_reset), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {stop, cpu_halt, stopped, div_reset, busy};
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; cpu_en = 1'b0; stop_exec = 1'b0;
    prepare_switch = 1'b0; cgb = 1'b0; joypad_any = 1'b0;

    tick(); tick();
    chk("reset_held", O_IDLE);
    reset_n = 1'b1;
    tick();
    chk("reset_release", O_IDLE);

    // Fast-mode speed switch
    cgb = 1'b1; prepare_switch = 1'b1; cpu_en = 1'b1; stop_exec = 1'b1;
    tick(); stop_exec = 1'b0;
    chk("sw_fast_entry", O_SW_ENT);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("sw_fast_hold", O_SW);
    end
    tick(); chk("sw_fast_exit", O_IDLE);

    // Slow-mode speed switch: cpu_en every 4th clk
    stop_exec = 1'b1; cpu_en = 1'b1;
    tick(); stop_exec = 1'b0; cpu_en = 1'b0;
    chk("sw_slow_entry", O_SW_ENT);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("sw_slow_gap0", O_SW);
    end
    for (int k = 1; k <= 4; k++) begin
      cpu_en = 1'b1;
      tick(); cpu_en = 1'b0;
      chk("sw_slow_tick", (k < 4) ? O_SW : O_IDLE);
      for (int i = 0; i < 3; i++) begin
        tick(); chk("sw_slow_gap", (k < 4) ? O_SW : O_IDLE);
      end
    end

    // Low-power STOP held 100 clks, then joypad wake
    cgb = 1'b0; prepare_switch = 1'b0; joypad_any = 1'b0;
    cpu_en = 1'b1; stop_exec = 1'b1;
    tick(); stop_exec = 1'b0;
    chk("stp_entry", O_STP_ENT);
    for (int i = 0; i < 100; i++) begin
      tick(); chk("stp_hold", O_STP);
    end
    joypad_any = 1'b1; cpu_en = 1'b0;
    tick();
    chk("wake_entry", O_WAKE);
    tick();
    chk("wake_no_en", O_WAKE);
    joypad_any = 1'b0; cpu_en = 1'b1;
    tick(); chk("wake_tick1", O_WAKE);
    tick(); chk("wake_tick2_exit", O_IDLE);

    // STOP as NOP while a button is held
    joypad_any = 1'b1; stop_exec = 1'b1; cpu_en = 1'b1;
    tick(); stop_exec = 1'b0;
    chk("nop_joypad", O_IDLE);
    tick(); chk("nop_joypad_after", O_IDLE);
    joypad_any = 1'b0;

    // stop_exec without cpu_en is ignored
    cpu_en = 1'b0; stop_exec = 1'b1;
    tick(); stop_exec = 1'b0;
    chk("no_cpu_en", O_IDLE);
    tick(); chk("no_cpu_en_after", O_IDLE);

    // Back-to-back speed switches give a fresh rising edge
    cgb = 1'b1; prepare_switch = 1'b1; cpu_en = 1'b1; stop_exec = 1'b1;
    tick(); stop_exec = 1'b0;
    chk("b2b_first", O_SW_ENT);
    for (int i = 0; i < 3; i++) tick();
    chk("b2b_first_last", O_SW);
    tick(); chk("b2b_gap_low", O_IDLE);
    stop_exec = 1'b1;
    tick(); stop_exec = 1'b0;
    chk("b2b_second_rise", O_SW_ENT);
    for (int i = 0; i < 3; i++) tick();
    tick(); chk("b2b_second_exit", O_IDLE);

    // Async reset mid-SWITCH with counter=2
    stop_exec = 1'b1;
    tick(); stop_exec = 1'b0;
    tick(); chk("rst_sw_pre", O_SW);
    #2 reset_n = 1'b0;
    #1 chk("rst_sw_async", O_IDLE);
    tick(); chk("rst_sw_held", O_IDLE);
    reset_n = 1'b1;
    tick(); chk("rst_sw_release", O_IDLE);

    // Post-reset STOP behaves as from power-on, then reset mid-STOPPED
    cgb = 1'b0; prepare_switch = 1'b0; stop_exec = 1'b1;
    tick(); stop_exec = 1'b0;
    chk("rst_stp_entry", O_STP_ENT);
    tick(); chk("rst_stp_pre", O_STP);
    #2 reset_n = 1'b0;
    #1 chk("rst_stp_async", O_IDLE);
    tick();
    reset_n = 1'b1;
    tick(); chk("rst_stp_release", O_IDLE);

    // Fresh speed switch after reset
    cgb = 1'b1; prepare_switch = 1'b1; stop_exec = 1'b1;
    tick(); stop_exec = 1'b0;
    chk("post_rst_sw_entry", O_SW_ENT);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("post_rst_sw_hold", O_SW);
    end
    tick(); chk("post_rst_sw_exit", O_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
